// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the low rate, zero-stuff by RATE, integrator chain at the high rate.
// Output is scaled by R^(N-1) so that DC gain is exactly one.
module cic_interpolator #(
   parameter int DATA_WIDTH = 16,
   parameter int N_STAGES   = 3,
   parameter int RATE       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_valid,
   output logic                         underflow
);

   localparam int L     = (RATE > 1) ? $clog2(RATE) : 1;
   localparam int W     = DATA_WIDTH + N_STAGES * L;
   localparam int SHIFT = (N_STAGES - 1) * L;

   logic [L-1:0]                phase_q, phase_d;
   logic signed [W-1:0]         d_q [N_STAGES];
   logic signed [W-1:0]         d_d [N_STAGES];
   logic signed [W-1:0]         i_q [N_STAGES];
   logic signed [W-1:0]         i_d [N_STAGES];
   logic signed [W-1:0]         z_q, z_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic                        underflow_q, underflow_d;

   logic                        slot;
   logic signed [W-1:0]         acc;
   logic signed [W-1:0]         shifted;

   assign slot      = en && (phase_q == '0);
   assign in_ready  = slot;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign underflow = underflow_q;

   always_comb begin
      phase_d     = phase_q;
      z_d         = z_q;
      out_data_d  = out_data_q;
      out_valid_d = en;
      underflow_d = underflow_q;
      for (int k = 0; k < N_STAGES; k++) begin
         d_d[k] = d_q[k];
         i_d[k] = i_q[k];
      end

      // A missing sample in its slot is replaced by zero.
      acc     = in_valid ? {{(W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data} : '0;
      shifted = i_q[N_STAGES-1] >>> SHIFT;

      if (en) begin
         phase_d = phase_q + 1'b1;
         z_d     = '0;
         if (slot) begin
            for (int k = 0; k < N_STAGES; k++) begin
               d_d[k] = acc;
               acc    = acc - d_q[k];
            end
            z_d = acc;
            if (!in_valid) begin
               underflow_d = 1'b1;
            end
         end
         // Each integrator uses the pre-update value of the previous stage.
         i_d[0] = i_q[0] + z_q;
         for (int k = 1; k < N_STAGES; k++) begin
            i_d[k] = i_q[k] + i_q[k-1];
         end
         out_data_d = shifted[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= '0;
         z_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         underflow_q <= 1'b0;
         for (int k = 0; k < N_STAGES; k++) begin
            d_q[k] <= '0;
            i_q[k] <= '0;
         end
      end else begin
         phase_q     <= phase_d;
         z_q         <= z_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         underflow_q <= underflow_d;
         for (int k = 0; k < N_STAGES; k++) begin
            d_q[k] <= d_d[k];
            i_q[k] <= i_d[k];
         end
      end
   end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (16-bit, 3 stages, rate 4): impulse, DC, step, underflow, enable gating.
module tb_cic_interpolator;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               in_ready;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               underflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [15:0] slot_data  [0:63];
   bit                 slot_valid [0:63];
   logic signed [15:0] obs        [0:255];
   int                 e_cnt;

   int imp [0:9] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
   int dip [0:9] = '{937, 812, 625, 375, 250, 250, 375, 625, 812, 937};

   cic_interpolator #(.DATA_WIDTH(16), .N_STAGES(3), .RATE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Applies reset asynchronously mid-cycle and checks outputs clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      en       = 1'b0;
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs n_en enabled cycles; gated selects a 1-on/2-off enable pattern.
   task automatic run(input int n_en, input bit gated);
      int cyc;
      bit en_v;
      cyc   = 0;
      e_cnt = 0;
      while (e_cnt < n_en) begin
         en_v = gated ? (cyc % 3 == 0) : 1'b1;
         @(negedge clk);
         en       = en_v;
         in_valid = slot_valid[e_cnt / 4];
         in_data  = slot_data[e_cnt / 4];
         #1;
         chk("in_ready", in_ready, en_v && (e_cnt % 4 == 0));
         @(posedge clk);
         #1;
         chk("out_valid", out_valid, en_v);
         if (en_v) begin
            obs[e_cnt] = out_data;
            e_cnt++;
         end
         cyc++;
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic set_slots(input logic signed [15:0] v);
      for (int s = 0; s < 64; s++) begin
         slot_data[s]  = v;
         slot_valid[s] = 1'b1;
      end
   endtask

   task automatic check_dip(input string tag);
      for (int e = 40; e < 80; e++) begin
         chk(tag, obs[e], (e >= 52 && e <= 61) ? dip[e-52] : 1000);
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_out_data", out_data, 0);
      chk("init_out_valid", out_valid, 0);
      chk("init_underflow", underflow, 0);
      @(negedge clk);
      rst = 1'b0;

      // Impulse: 16 in the first slot, zero afterwards.
      set_slots(16'sd0);
      slot_data[0] = 16'sd16;
      run(24, 1'b0);
      for (int e = 0; e < 4; e++) chk("imp_lead", obs[e], 0);
      for (int e = 4; e < 14; e++) chk("imp_shape", obs[e], imp[e-4]);
      for (int e = 14; e < 24; e++) chk("imp_tail", obs[e], 0);
      chk("imp_underflow", underflow, 0);

      // DC gain.
      do_reset();
      set_slots(16'sd1000);
      run(60, 1'b0);
      for (int e = 40; e < 60; e++) chk("dc_level", obs[e], 1000);
      chk("dc_underflow", underflow, 0);

      // Reset while the output sits at 1000.
      do_reset();

      // Full-scale step.
      set_slots(-16'sd32768);
      for (int s = 10; s < 64; s++) slot_data[s] = 16'sd32767;
      run(80, 1'b0);
      for (int e = 36; e < 40; e++) chk("step_low", obs[e], -32768);
      for (int e = 37; e < 80; e++) chk("step_mono", obs[e] >= obs[e-1], 1);
      for (int e = 70; e < 80; e++) chk("step_high", obs[e], 32767);

      // Missed slot during DC, continuous enable.
      do_reset();
      set_slots(16'sd1000);
      slot_valid[12] = 1'b0;
      run(80, 1'b0);
      check_dip("ufl_dip");
      chk("ufl_set", underflow, 1);
      slot_valid[12] = 1'b1;
      run(8, 1'b0);
      chk("ufl_sticky", underflow, 1);

      // Same stream with gated enable must match per enabled cycle.
      do_reset();
      slot_valid[12] = 1'b0;
      run(80, 1'b1);
      check_dip("gate_dip");
      chk("gate_ufl", underflow, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

CIC interpolation filter: the transmit-side counterpart of the decimating CIC chain. It takes low-rate samples through a ready/valid handshake and runs them through `N_STAGES` comb stages. It then zero-stuffs by `RATE` and passes the result through `N_STAGES` integrator stages. One output sample is produced on every enabled high-rate cycle, with unity DC gain. It sits at the input of the DFE upsampling path, driven by the block-level clock enable.

## Interface
- `DATA_WIDTH`, 16: width of input and output samples (signed two's complement).
- `N_STAGES`, 3: number of comb stages, equal to the number of integrator stages (≥1).
- `RATE`, 4: interpolation factor. Must be a power of two, ≥2. Differential delay is fixed at 1.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  high-rate clock enable. All state, including the phase counter, holds when low.
- `in_valid`  input  1  `in_data` holds a valid low-rate sample.
- `in_data`  input  DATA_WIDTH  signed low-rate input sample.
- `in_ready`  output  1  combinational: `en && (phase == 0)`.
- `out_data`  output  DATA_WIDTH  signed high-rate output sample (registered).
- `out_valid`  output  1  registered; `out_data` updated this cycle.
- `underflow`  output  1  sticky flag: an input slot passed without a sample.

## Operation
**Widths**
- `L = log2(RATE)`.
- Internal width `W = DATA_WIDTH + N_STAGES*L`.
- All comb/integrator arithmetic is W-bit two's complement, wrap-around (modular). No saturation is needed internally.

**Phase counter**
- `phase` runs 0..RATE-1.
- Increments on each `en` cycle and wraps from RATE-1 to 0.

**Slot cycle** (`en && phase == 0`)
- If `in_valid`: sample accepted. Sign-extend to W.
- If `!in_valid`: the value 0 is used instead and `underflow` is set.
- The comb chain is evaluated combinationally from that value: `c_k = c_{k-1} - d_k`, where `d_k` is the stage's delay register.
- Every `d_k` loads its stage input.
- `z` (zero-stuff register) loads `c_N`.

**Other en cycles**
- Comb delays hold.
- `z` loads 0.

**Integrators** (every en cycle)
- `i_1 <= i_1 + z`.
- `i_k <= i_k + i_{k-1}` for k = 2..N, using pre-update values (a registered pipeline).

**Output**
- `out_data <= i_N >>> ((N_STAGES-1)*L)`, truncated to the low DATA_WIDTH bits.
- This divides out the R^(N-1) CIC gain, so DC gain is exactly 1.
- The result always fits DATA_WIDTH for in-range input.

**Flags**
- `out_valid <= en`.
- `underflow` stays set until `rst`.

**Other rules**
- `in_valid` high while `in_ready` low: the sample is not consumed. The source must hold it until the next slot.
- `en` low: nothing changes, `out_valid` deasserts next cycle, `in_ready` stays low.

## Timing
**Reset values**
- Async `rst` clears `phase`, every `d_k`, `z`, every `i_k`, `out_data`, `out_valid` and `underflow` to 0 immediately.
- First slot after reset release is the first en cycle.

**Throughput**
- One accepted sample per RATE enabled cycles.
- One output per enabled cycle.

**Latency**
- Sample accepted at enabled cycle t: its first contribution appears on `out_data` after enabled cycle t+N_STAGES+1, i.e. visible at t+N_STAGES+2.
- Impulse response spans `N_STAGES*(RATE-1)+1` outputs.

**Reset mid-operation**
- All in-flight samples are discarded.
- Output returns to 0.
- Next accepted sample restarts cleanly at phase 0.

**Backpressure**
- There is no output-side backpressure. The consumer must accept every `out_valid` beat.

## Test plan
Defaults throughout: DATA_WIDTH=16, N_STAGES=3, RATE=4, so W=22 and shift=4.

1. **Reset:** assert `rst` mid-stream. → `out_data`=0, `out_valid`=0, `underflow`=0, `in_ready`=0 while `en`=0. After release with `en`=1, `in_ready`=1 on the first cycle, then every 4th cycle.
2. **Impulse:** `en`=1, in_data=16 once, then 0 each slot. → 10 nonzero outputs 1,3,6,10,12,12,10,6,3,1, first appearing N_STAGES+2 = 5 enabled cycles after acceptance. Zeros thereafter.
3. **DC:** constant in_data=1000. → after settling, `out_data`=1000 on every enabled cycle.
4. **Full-scale step:** in_data=-32768 held, then 32767 held. → outputs settle exactly at -32768 and 32767, monotonic transition, no wrap glitch.
5. **Underflow and enable gating:** drop `in_valid` on one slot during DC=1000. → `underflow`=1 and stays set; output dips per the impulse shape, then recovers to 1000. Then toggle `en` in a 1-on/2-off pattern. → output sequence identical to the continuous-en run, indexed by enabled cycles; `out_valid` high only after en cycles.
